// File: rtl/tone_pkg.sv
// Shared definitions for the tone path: preset width, rest code and FSM states.
// The note encoder uses TO_REST as its silence value.
package tone_pkg;

    localparam int TO_W = 11;
    localparam logic [TO_W-1:0] TO_REST = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REST = 2'd1,
        RUN  = 2'd2
    } tone_state_e;

endpackage

// File: rtl/tone_prescaler.sv
// Tone tick prescaler: one-cycle tick every CLK_DIV clocks while EN is high.
// EN low parks the count at zero so a re-enable always starts a full tick interval.
module tone_prescaler #(
    parameter int CLK_DIV = 12
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic tick
);

    // CLK_DIV=1 still needs a one-bit counter; it simply never leaves zero.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt;

    assign tick = EN && (pcnt == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt <= '0;
        end else if (!EN || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator: reloadable up-counter sets each half-period and SPKS
// toggles at every boundary. TO is sampled only at boundaries, so pitch changes are glitch-free.
module tone_gen #(
    parameter int CLK_DIV = 12,
    parameter int TO_W    = tone_pkg::TO_W
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic [TO_W-1:0] TO,
    output logic            SPKS,
    output logic            RELOAD_STB,
    output logic [TO_W-1:0] TO_LAT,
    output logic            RESTING
);

    import tone_pkg::*;

    localparam logic [TO_W-1:0] REST_CODE = TO_W'(TO_REST);

    tone_state_e     state;
    logic [TO_W-1:0] cnt;
    logic            tick;

    tone_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_pre (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (EN),
        .tick (tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= REST_CODE;
            TO_LAT     <= REST_CODE;
            SPKS       <= 1'b0;
            RELOAD_STB <= 1'b0;
            RESTING    <= 1'b1;
        end else begin
            RELOAD_STB <= 1'b0;
            if (!EN) begin
                state   <= IDLE;
                cnt     <= REST_CODE;
                TO_LAT  <= REST_CODE;
                SPKS    <= 1'b0;
                RESTING <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= REST;
                    end
                    REST: begin
                        // Leaving rest is a load, not a boundary: no strobe, SPKS stays low.
                        if (tick && TO != REST_CODE) begin
                            TO_LAT  <= TO;
                            cnt     <= TO;
                            state   <= RUN;
                            RESTING <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (cnt != REST_CODE) begin
                                cnt <= cnt + TO_W'(1);
                            end else begin
                                // Half-period boundary: the only point where TO is observed.
                                RELOAD_STB <= 1'b1;
                                TO_LAT     <= TO;
                                if (TO != REST_CODE) begin
                                    cnt  <= TO;
                                    SPKS <= ~SPKS;
                                end else begin
                                    SPKS    <= 1'b0;
                                    state   <= REST;
                                    RESTING <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        RESTING <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: three instances (CLK_DIV 4, 1, 12) driven in one linear sequence.
// Expected values are hand-derived edge counts relative to enable/load points.
module tb_tone_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en4, en1, en12;
    logic [10:0] to4, to1, to12;
    logic        spks4, stb4, rest4;
    logic        spks1, stb1, rest1;
    logic        spks12, stb12, rest12;
    logic [10:0] tolat4, tolat1, tolat12;

    int checks = 0;
    int passes = 0;
    int n;
    int total;

    always #5 clk = ~clk;

    tone_gen #(.CLK_DIV(4)) u4 (
        .CLK(clk), .RST_N(rst_n), .EN(en4), .TO(to4),
        .SPKS(spks4), .RELOAD_STB(stb4), .TO_LAT(tolat4), .RESTING(rest4)
    );

    tone_gen #(.CLK_DIV(1)) u1 (
        .CLK(clk), .RST_N(rst_n), .EN(en1), .TO(to1),
        .SPKS(spks1), .RELOAD_STB(stb1), .TO_LAT(tolat1), .RESTING(rest1)
    );

    tone_gen #(.CLK_DIV(12)) u12 (
        .CLK(clk), .RST_N(rst_n), .EN(en12), .TO(to12),
        .SPKS(spks12), .RELOAD_STB(stb12), .TO_LAT(tolat12), .RESTING(rest12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1ns after the last one.
    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Count cycles until spks12 reaches lvl, giving up after budget cycles.
    task automatic wait_spks12(input logic lvl, input int budget, output int cycles);
        cycles = 0;
        while (spks12 !== lvl && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en4 = 1'b0; en1 = 1'b0; en12 = 1'b0;
        to4 = 11'h7FC; to1 = 11'h7FE; to12 = 11'h7FE;

        // Reset state
        step(1);
        check("rst_spks4",   spks4,  0);
        check("rst_stb4",    stb4,   0);
        check("rst_tolat4",  tolat4, 11'h7FF);
        check("rst_rest4",   rest4,  1);
        check("rst_tolat1",  tolat1, 11'h7FF);
        check("rst_rest12",  rest12, 1);
        #4 rst_n = 1'b1;
        step(1);

        // CLK_DIV=1, TO=7FE: 2-CLK half-periods, then 7FD taken only at the boundary
        en1 = 1'b1;
        step(1);  check("d1_idle_rest", rest1, 1);
        step(1);  check("d1_load_run",  rest1, 0);
                  check("d1_load_tl",   tolat1, 11'h7FE);
                  check("d1_load_spk",  spks1, 0);
        step(1);  check("d1_g3_spk",    spks1, 0);
                  check("d1_g3_stb",    stb1,  0);
        step(1);  check("d1_g4_spk",    spks1, 1);
                  check("d1_g4_stb",    stb1,  1);
        step(1);  check("d1_g5_spk",    spks1, 1);
                  check("d1_g5_stb",    stb1,  0);
        step(1);  check("d1_g6_spk",    spks1, 0);
        step(1);  check("d1_g7_spk",    spks1, 0);
        to1 = 11'h7FD;
        step(1);  check("d1_g8_spk",    spks1, 1);
                  check("d1_g8_tl",     tolat1, 11'h7FD);
        step(2);  check("d1_g10_spk",   spks1, 1);
        step(1);  check("d1_g11_spk",   spks1, 0);
                  check("d1_g11_stb",   stb1,  1);
        step(2);  check("d1_g13_spk",   spks1, 0);
        step(1);  check("d1_g14_spk",   spks1, 1);
        en1 = 1'b0;
        step(1);  check("d1_off_spk",   spks1, 0);
                  check("d1_off_rest",  rest1, 1);

        // CLK_DIV=4, TO=7FC: load on first tick, toggle every 16 CLK
        en4 = 1'b1;
        step(1);  check("s1_rest",      rest4, 1);
        step(3);  check("s1_run",       rest4, 0);
                  check("s1_tl",        tolat4, 11'h7FC);
                  check("s1_load_stb",  stb4,  0);
        step(15); check("s1_e19_spk",   spks4, 0);
                  check("s1_e19_stb",   stb4,  0);
        step(1);  check("s1_e20_spk",   spks4, 1);
                  check("s1_e20_stb",   stb4,  1);
        step(1);  check("s1_e21_stb",   stb4,  0);
        step(14); check("s1_e35_spk",   spks4, 1);
        step(1);  check("s1_e36_spk",   spks4, 0);
                  check("s1_e36_stb",   stb4,  1);

        // Rest code at the next boundary, then resume
        to4 = 11'h7FF;
        step(15); check("s3_e51_spk",   spks4, 0);
                  check("s3_e51_rest",  rest4, 0);
        step(1);  check("s3_e52_stb",   stb4,  1);
                  check("s3_e52_rest",  rest4, 1);
                  check("s3_e52_tl",    tolat4, 11'h7FF);
        to4 = 11'h7FC;
        step(3);  check("s3_e55_rest",  rest4, 1);
        step(1);  check("s3_e56_rest",  rest4, 0);
                  check("s3_e56_stb",   stb4,  0);
                  check("s3_e56_tl",    tolat4, 11'h7FC);
        step(15); check("s3_e71_spk",   spks4, 0);
        step(1);  check("s3_e72_spk",   spks4, 1);
                  check("s3_e72_stb",   stb4,  1);

        // One-cycle EN drop forces IDLE, then IDLE->REST->RUN again
        en4 = 1'b0;
        step(1);  check("s4_spk",       spks4, 0);
                  check("s4_tl",        tolat4, 11'h7FF);
                  check("s4_rest",      rest4, 1);
                  check("s4_stb",       stb4,  0);
                  check("s4_pcnt",      u4.u_pre.pcnt, 0);
        en4 = 1'b1;
        step(1);  check("s4_idle_rest", rest4, 1);
        step(3);  check("s4_run",       rest4, 0);
        step(15); check("s4_pre_spk",   spks4, 0);
        step(1);  check("s4_rise_spk",  spks4, 1);
                  check("s4_rise_stb",  stb4,  1);

        // Asynchronous reset between edges right after a rise
        #3 rst_n = 1'b0;
        #1;
        check("s5_spk",   spks4, 0);
        check("s5_stb",   stb4,  0);
        check("s5_tl",    tolat4, 11'h7FF);
        check("s5_rest",  rest4, 1);
        #10 rst_n = 1'b1;
        step(1);  check("s5_f1_rest",   rest4, 1);
        step(3);  check("s5_f4_run",    rest4, 0);
                  check("s5_f4_tl",     tolat4, 11'h7FC);
        step(15); check("s5_f19_spk",   spks4, 0);
        step(1);  check("s5_f20_spk",   spks4, 1);
                  check("s5_f20_stb",   stb4,  1);
        en4 = 1'b0;

        // CLK_DIV=12, TO=305: three full periods of 30600 CLK
        en12 = 1'b1;
        wait_spks12(1'b1, 2000, n);
        check("s6_first_rise", spks12, 1);
        to12 = 11'h305;
        wait_spks12(1'b0, 200, n);
        check("s6_switch_fall", spks12, 0);
        check("s6_tl", tolat12, 11'h305);
        total = 0;
        for (int i = 0; i < 6; i++) begin
            wait_spks12(~spks12, 20000, n);
            check($sformatf("s6_half%0d", i), n, 15300);
            total += n;
        end
        check("s6_three_periods", total, 30600 * 3);
        check("s6_rest", rest12, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream of the note-to-divider encoder. Consumes its 11-bit divider preset TO and drives a square wave on the speaker pin.
- A prescaler derives a tone tick from CLK. An 11-bit reloadable up-counter sets each half-period, and SPKS toggles at every half-period boundary.
- The preset TO = 11'h7FF is the rest code (silence).
- A new TO is only taken at a half-period boundary, so pitch changes never produce glitches.

Parameters:
- CLK_DIV, 12, CLK cycles per tone tick; legal range is 1 or more (1 = tick every cycle).
- TO_W, 11, width of the divider preset.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous reset, active low.
- EN  in  1  tone enable, synchronous. Low forces the idle state.
- TO  in  11  divider preset from the encoder; 11'h7FF means rest.
- SPKS  out  1  speaker square wave.
- RELOAD_STB  out  1  one-CLK pulse on each half-period reload.
- TO_LAT  out  11  preset currently governing the counter.
- RESTING  out  1  high while in IDLE or REST.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - prescaler=0, cnt=11'h7FF, TO_LAT=11'h7FF, SPKS=0, RELOAD_STB=0, RESTING=1, state=IDLE.
  - Asserting reset in the middle of a note aborts it immediately.
  - Release is synchronous to CLK.
- Prescaler:
  - pcnt counts 0..CLK_DIV-1 while EN=1.
  - tick=1 in the cycle where pcnt==CLK_DIV-1, then pcnt wraps to 0.
  - EN=0 clears pcnt to 0 on the next edge.
- States:
  - IDLE: the state while EN=0.
  - REST: the state when EN=1 and TO_LAT==7FF.
  - RUN: the tone is sounding.
- Transitions and actions:
  - Any state with EN=0: at the next edge go to IDLE with SPKS=0, cnt=7FF, TO_LAT=7FF. No strobe is issued.
  - IDLE, EN=1: go to REST. No sampling happens yet.
  - REST, on a tick:
    - If TO!=7FF: TO_LAT<=TO, cnt<=TO, SPKS stays 0, go to RUN.
    - If TO==7FF: stay in REST.
    - No strobe is issued in either case.
  - RUN, on a tick with cnt!=7FF: cnt<=cnt+1.
  - RUN, on a tick with cnt==7FF (boundary):
    - RELOAD_STB=1 for that cycle and TO_LAT<=TO.
    - If TO!=7FF: cnt<=TO and SPKS toggles.
    - If TO==7FF: SPKS<=0 and go to REST.
  - Cycles without a tick: no state change.
- Timing rules:
  - Half-period = (2048 - TO_LAT) ticks = (2048 - TO_LAT) * CLK_DIV CLK cycles.
  - f_SPKS = f_CLK / (2 * CLK_DIV * (2048 - TO_LAT)).
  - Changes on TO between boundaries are ignored, even if several changes occur.
  - TO=11'h7FE gives the minimum half-period of 2 ticks.
  - First SPKS rise occurs 2048-TO ticks after the load tick.
- Arithmetic: the counter is 11-bit unsigned. It never wraps past 7FF, because 7FF always triggers a reload.
- Outputs: all are registered. RESTING = (state != RUN).

Decomposition:
- Shared package tone_pkg holds:
  - TO_W=11
  - TO_REST=11'h7FF
  - state enum {IDLE, REST, RUN}
- The encoder uses TO_REST as its rest value.
- One sub-module, tone_prescaler (CLK_DIV parameter; inputs CLK, RST_N, EN; output tick). The remainder is a single FSM+counter.

Test Plan:
- CLK_DIV=4, EN=1, TO=11'h7FC held → REST→RUN on the first tick. SPKS toggles every 16 CLK, RELOAD_STB pulses every 16 CLK, TO_LAT=7FC, RESTING=0.
- CLK_DIV=1, TO=11'h7FE → SPKS toggles every 2 CLK. Then set TO=11'h7FD mid half-period → the current half-period stays 2 CLK and all following half-periods are 3 CLK.
- Running at TO=7FC, drive TO=11'h7FF → at the next boundary SPKS=0, RESTING=1, state REST. Restore TO=7FC → tone resumes with its first toggle 4 ticks after the load tick.
- Running, drop EN for 1 cycle → next edge gives SPKS=0, TO_LAT=7FF, RESTING=1, pcnt=0. Re-raising EN restarts from IDLE→REST.
- Assert RST_N low asynchronously between edges mid-run → outputs take reset values immediately. After release with EN=1, TO=7FC, timing matches the first scenario.
- CLK_DIV=12, TO=11'h305 → SPKS period = 2*12*1275 = 30600 CLK, measured over 3 full periods.
